// File: rtl/csr_pkg.sv
// CSR register file shared definitions: addresses, field positions, writable masks, exception codes.
// Latency: none (constants and a pure function only).
// Backpressure: none.
package csr_pkg;

   // CSR addresses
   localparam logic [13:0] CSR_CRMD   = 14'h000;
   localparam logic [13:0] CSR_PRMD   = 14'h001;
   localparam logic [13:0] CSR_ECFG   = 14'h004;
   localparam logic [13:0] CSR_ESTAT  = 14'h005;
   localparam logic [13:0] CSR_ERA    = 14'h006;
   localparam logic [13:0] CSR_BADV   = 14'h007;
   localparam logic [13:0] CSR_EENTRY = 14'h00C;
   localparam logic [13:0] CSR_SAVE0  = 14'h030;
   localparam logic [13:0] CSR_SAVE1  = 14'h031;
   localparam logic [13:0] CSR_SAVE2  = 14'h032;
   localparam logic [13:0] CSR_SAVE3  = 14'h033;
   localparam logic [13:0] CSR_TID    = 14'h040;
   localparam logic [13:0] CSR_TCFG   = 14'h041;
   localparam logic [13:0] CSR_TVAL   = 14'h042;
   localparam logic [13:0] CSR_TICLR  = 14'h044;

   // Field bit positions
   localparam int CRMD_PLV_LSB   = 0;
   localparam int CRMD_IE        = 2;
   localparam int PRMD_PPLV_LSB  = 0;
   localparam int PRMD_PIE       = 2;
   localparam int ESTAT_IS_TI    = 11;
   localparam int ESTAT_IS_IPI   = 12;
   localparam int ESTAT_ECODE_LSB = 16;
   localparam int ESTAT_ESUB_LSB = 22;
   localparam int TCFG_EN        = 0;
   localparam int TCFG_PERIODIC  = 1;
   localparam int TICLR_CLR      = 0;

   // Software-writable bit masks
   localparam logic [31:0] CRMD_WMASK   = 32'h0000_001F;
   localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
   localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
   localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
   localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
   localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;
   localparam logic [31:0] TCFG_WMASK   = 32'hFFFF_FFFF;

   // Reset values that are not zero
   localparam logic [31:0] CRMD_RESET = 32'h0000_0008;
   localparam logic [31:0] TVAL_RESET = 32'hFFFF_FFFF;

   // Exception codes
   localparam logic [5:0] ECODE_INT     = 6'h00;
   localparam logic [5:0] ECODE_ADE     = 6'h08;
   localparam logic [5:0] ECODE_ALE     = 6'h09;
   localparam logic [5:0] ECODE_SYS     = 6'h0B;
   localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
   localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

   // Masked CSR update restricted to the bits software may change
   function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                             input logic [31:0] wvalue,
                                             input logic [31:0] wmask,
                                             input logic [31:0] swmask);
      logic [31:0] m;
      m = wmask & swmask;
      return (old_val & ~m) | (wvalue & m);
   endfunction

endpackage

// File: rtl/csr_timer.sv
// Timer CSRs: TCFG, TVAL countdown and the timer interrupt flag (ESTAT.IS[11]); built only with CSR_TIMER_EN.
// Latency: writes and countdown take effect at the next clk edge; outputs are registered.
// Backpressure: none; a write is always accepted in the cycle csr_we is high.
`ifdef CSR_TIMER_EN
module csr_timer
   import csr_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        tcfg_we,
   input  logic        ticlr_we,
   input  logic [31:0] wmask,
   input  logic [31:0] wvalue,
   output logic [31:0] tcfg,
   output logic [31:0] tval,
   output logic        timer_int
);

   logic [31:0] tcfg_new;
   logic        fire;
   logic        clear;

   assign tcfg_new = csr_merge(tcfg, wvalue, wmask, TCFG_WMASK);
   // A fresh TCFG write reloads the counter, so it never counts as a 1->0 step
   assign fire     = !tcfg_we && tcfg[TCFG_EN] && (tval == 32'd1);
   assign clear    = ticlr_we && wvalue[TICLR_CLR] && wmask[TICLR_CLR];

   // Configuration register and countdown with optional periodic reload
   always_ff @(posedge clk) begin
      if (reset) begin
         tcfg <= '0;
         tval <= TVAL_RESET;
      end else if (tcfg_we) begin
         tcfg <= tcfg_new;
         tval <= {tcfg_new[31:2], 2'b00};
      end else if (tcfg[TCFG_EN]) begin
         if (tval != 32'd0)
            tval <= tval - 32'd1;
         else if (tcfg[TCFG_PERIODIC])
            tval <= {tcfg[31:2], 2'b00};
      end
   end

   // Interrupt flag: a timer expiry in the same cycle beats a software clear
   always_ff @(posedge clk) begin
      if (reset)
         timer_int <= 1'b0;
      else if (fire)
         timer_int <= 1'b1;
      else if (clear)
         timer_int <= 1'b0;
   end

endmodule
`endif

// File: rtl/csr_regfile.sv
// Control/status register file: exception state, interrupt status/enable, save regs, optional timer (CSR_TIMER_EN).
// Latency: reads are combinational (pre-update value); writes, exception and ertn updates land at the next clk edge.
// Backpressure: none; every write, exception commit and ertn is accepted in the cycle it is presented.
module csr_regfile
   import csr_pkg::*;
#(
   parameter logic [31:0] COREID = 32'd0
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        csr_re,
   input  logic [13:0] csr_num,
   output logic [31:0] csr_rvalue,
   input  logic        csr_we,
   input  logic [31:0] csr_wmask,
   input  logic [31:0] csr_wvalue,
   input  logic        wb_ex,
   input  logic        ertn_flush,
   input  logic [5:0]  wb_ecode,
   input  logic [8:0]  wb_esubcode,
   input  logic [31:0] wb_pc,
   input  logic [31:0] wb_vaddr,
   input  logic [7:0]  hw_int_in,
   input  logic        ipi_int_in,
   output logic        has_int,
   output logic [31:0] ex_entry,
   output logic [31:0] ertn_entry
);

   logic [31:0] crmd, prmd, ecfg, era, badv, eentry, tid;
   logic [31:0] save [0:3];
   logic [1:0]  estat_is_sw;
   logic [7:0]  estat_is_hw;
   logic        estat_is_ipi;
   logic [5:0]  estat_ecode;
   logic [8:0]  estat_esub;
   logic [31:0] estat_rvalue;
   logic [31:0] tcfg, tval;
   logic        timer_is;
   logic        unused_csr_re;

   // Reads never have side effects, so the enable carries no information here
   assign unused_csr_re = csr_re;

   logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry, wr_tid, wr_save;
   logic badv_from_pc, badv_from_vaddr;

   assign wr_crmd   = csr_we && (csr_num == CSR_CRMD);
   assign wr_prmd   = csr_we && (csr_num == CSR_PRMD);
   assign wr_ecfg   = csr_we && (csr_num == CSR_ECFG);
   assign wr_estat  = csr_we && (csr_num == CSR_ESTAT);
   assign wr_era    = csr_we && (csr_num == CSR_ERA);
   assign wr_badv   = csr_we && (csr_num == CSR_BADV);
   assign wr_eentry = csr_we && (csr_num == CSR_EENTRY);
   assign wr_tid    = csr_we && (csr_num == CSR_TID);
   assign wr_save   = csr_we && (csr_num[13:2] == CSR_SAVE0[13:2]);

   assign badv_from_pc    = wb_ex && (wb_ecode == ECODE_ADE) && (wb_esubcode == ESUBCODE_ADEF);
   assign badv_from_vaddr = wb_ex && ((wb_ecode == ECODE_ALE) ||
                                      ((wb_ecode == ECODE_ADE) && (wb_esubcode == ESUBCODE_ADEM)));

   // CRMD/PRMD: software write first, exception or ertn overrides the PLV/IE fields
   always_ff @(posedge clk) begin
      if (reset) begin
         crmd <= CRMD_RESET;
         prmd <= '0;
      end else begin
         if (wr_crmd) crmd <= csr_merge(crmd, csr_wvalue, csr_wmask, CRMD_WMASK);
         if (wr_prmd) prmd <= csr_merge(prmd, csr_wvalue, csr_wmask, PRMD_WMASK);
         if (wb_ex) begin
            prmd[PRMD_PPLV_LSB +: 2] <= crmd[CRMD_PLV_LSB +: 2];
            prmd[PRMD_PIE]           <= crmd[CRMD_IE];
            crmd[CRMD_PLV_LSB +: 2]  <= 2'b00;
            crmd[CRMD_IE]            <= 1'b0;
         end else if (ertn_flush) begin
            crmd[CRMD_PLV_LSB +: 2]  <= prmd[PRMD_PPLV_LSB +: 2];
            crmd[CRMD_IE]            <= prmd[PRMD_PIE];
         end
      end
   end

   // Exception capture: return address, cause and bad address
   always_ff @(posedge clk) begin
      if (reset) begin
         era         <= '0;
         badv        <= '0;
         estat_ecode <= '0;
         estat_esub  <= '0;
      end else begin
         if (wb_ex) begin
            era         <= wb_pc;
            estat_ecode <= wb_ecode;
            estat_esub  <= wb_esubcode;
         end else if (wr_era) begin
            era <= csr_merge(era, csr_wvalue, csr_wmask, FULL_WMASK);
         end
         if (badv_from_vaddr)
            badv <= wb_vaddr;
         else if (badv_from_pc)
            badv <= wb_pc;
         else if (wr_badv)
            badv <= csr_merge(badv, csr_wvalue, csr_wmask, FULL_WMASK);
      end
   end

   // Interrupt status: software bits plus registered hardware and IPI lines
   always_ff @(posedge clk) begin
      if (reset) begin
         estat_is_sw  <= '0;
         estat_is_hw  <= '0;
         estat_is_ipi <= 1'b0;
      end else begin
         if (wr_estat)
            estat_is_sw <= (estat_is_sw & ~(csr_wmask[1:0] & ESTAT_WMASK[1:0])) |
                           (csr_wvalue[1:0] & csr_wmask[1:0] & ESTAT_WMASK[1:0]);
         estat_is_hw  <= hw_int_in;
         estat_is_ipi <= ipi_int_in;
      end
   end

   // Plain software registers
   always_ff @(posedge clk) begin
      if (reset) begin
         ecfg   <= '0;
         eentry <= '0;
         tid    <= COREID;
      end else begin
         if (wr_ecfg)   ecfg   <= csr_merge(ecfg, csr_wvalue, csr_wmask, ECFG_WMASK);
         if (wr_eentry) eentry <= csr_merge(eentry, csr_wvalue, csr_wmask, EENTRY_WMASK);
         if (wr_tid)    tid    <= csr_merge(tid, csr_wvalue, csr_wmask, FULL_WMASK);
      end
   end

   // Scratch registers SAVE0-3
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) save[i] <= '0;
      end else if (wr_save) begin
         save[csr_num[1:0]] <= csr_merge(save[csr_num[1:0]], csr_wvalue, csr_wmask, FULL_WMASK);
      end
   end

`ifdef CSR_TIMER_EN
   logic wr_tcfg, wr_ticlr;
   assign wr_tcfg  = csr_we && (csr_num == CSR_TCFG);
   assign wr_ticlr = csr_we && (csr_num == CSR_TICLR);

   csr_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .tcfg_we   (wr_tcfg),
      .ticlr_we  (wr_ticlr),
      .wmask     (csr_wmask),
      .wvalue    (csr_wvalue),
      .tcfg      (tcfg),
      .tval      (tval),
      .timer_int (timer_is)
   );
`else
   assign tcfg     = '0;
   assign tval     = '0;
   assign timer_is = 1'b0;
`endif

   assign estat_rvalue = {1'b0, estat_esub, estat_ecode, 3'b000, estat_is_ipi, timer_is,
                          1'b0, estat_is_hw, estat_is_sw};

   // Combinational read mux; unmapped addresses return zero
   always_comb begin
      csr_rvalue = '0;
      case (csr_num)
         CSR_CRMD:   csr_rvalue = crmd;
         CSR_PRMD:   csr_rvalue = prmd;
         CSR_ECFG:   csr_rvalue = ecfg;
         CSR_ESTAT:  csr_rvalue = estat_rvalue;
         CSR_ERA:    csr_rvalue = era;
         CSR_BADV:   csr_rvalue = badv;
         CSR_EENTRY: csr_rvalue = eentry;
         CSR_SAVE0:  csr_rvalue = save[0];
         CSR_SAVE1:  csr_rvalue = save[1];
         CSR_SAVE2:  csr_rvalue = save[2];
         CSR_SAVE3:  csr_rvalue = save[3];
         CSR_TID:    csr_rvalue = tid;
         CSR_TCFG:   csr_rvalue = tcfg;
         CSR_TVAL:   csr_rvalue = tval;
         default:    csr_rvalue = '0;
      endcase
   end

   assign has_int    = (|(estat_rvalue[12:0] & ecfg[12:0])) & crmd[CRMD_IE];
   assign ex_entry   = eentry;
   assign ertn_entry = era;

endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL have parameter: COREID, default 0, reset value of TID.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port: clk  in  1  clock.
REQ-004 SHALL have port: reset  in  1  synchronous active-high reset.
REQ-005 SHALL have port: csr_re  in  1  read enable (informational, read path is combinational).
REQ-006 SHALL have port: csr_num  in  14  CSR address.
REQ-007 SHALL have port: csr_rvalue  out  32  read data.
REQ-008 SHALL have port: csr_we  in  1  write enable.
REQ-009 SHALL have port: csr_wmask  in  32  bitwise write mask.
REQ-010 SHALL have port: csr_wvalue  in  32  write data.
REQ-011 SHALL have port: wb_ex  in  1  exception commit from writeback.
REQ-012 SHALL have port: ertn_flush  in  1  ertn commit.
REQ-013 SHALL have ports: wb_ecode  in  6  exception code; wb_esubcode  in  9  subcode.
REQ-014 SHALL have ports: wb_pc  in  32  faulting pc; wb_vaddr  in  32  faulting data address.
REQ-015 SHALL have ports: hw_int_in  in  8  hardware interrupt lines; ipi_int_in  in  1  inter-processor interrupt.
REQ-016 SHALL have port: has_int  out  1  pending enabled interrupt, to decode stage.
REQ-017 SHALL have ports: ex_entry  out  32  EENTRY value; ertn_entry  out  32  ERA value.

Function
REQ-018 SHALL implement CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44. Unmapped csr_num SHALL read 0 and ignore writes.
REQ-019 SHALL return csr_rvalue combinationally from csr_num, same cycle, pre-update value.
REQ-020 On csr_we, SHALL update at next posedge: new = (old & ~wmask) | (wvalue & wmask), restricted to software-writable bits. Read-only bits are unaffected.
REQ-021 CRMD fields SHALL be PLV[1:0], IE[2], DA[3], PG[4]. PRMD fields SHALL be PPLV[1:0], PIE[2]. ECFG.LIE writable bits SHALL be 9:0 and 12:11. EENTRY writable bits SHALL be 31:6.
REQ-022 ESTAT.IS[1:0] SHALL be software-writable. IS[9:2] SHALL take hw_int_in every cycle. IS[11] SHALL be the timer interrupt. IS[12] SHALL take ipi_int_in every cycle. Ecode SHALL be [21:16] and EsubCode [30:22], both read-only to software.
REQ-023 On wb_ex, the following updates SHALL occur at the next posedge:
- PPLV<=PLV, PIE<=IE, PLV<=0, IE<=0
- ERA<=wb_pc, Ecode<=wb_ecode, EsubCode<=wb_esubcode
- BADV<=wb_pc if ecode=ADE with esubcode=ADEF; BADV<=wb_vaddr if ecode=ALE, or ecode=ADE with esubcode=ADEM; otherwise BADV unchanged.
REQ-024 On ertn_flush, the next posedge SHALL set PLV<=PPLV and IE<=PIE.
REQ-025 When wb_ex or ertn_flush coincides with a csr_we to the same field, the exception/ertn update SHALL win.
REQ-026 has_int SHALL be (|(ESTAT.IS[12:0] & ECFG.LIE[12:0])) & CRMD.IE.
REQ-027 ex_entry SHALL be EENTRY. ertn_entry SHALL be ERA.

Reset
REQ-028 Reset SHALL set CRMD=0x00000008 (DA=1), TID=COREID, TCFG.En=0, TVAL=0xFFFFFFFF. All other CSR state SHALL be 0.
REQ-029 Reset SHALL take priority over wb_ex, ertn_flush and csr_we in the same cycle.

Configuration
REQ-030 With CSR_TIMER_EN defined, the following SHALL apply:
- TCFG fields: En[0], Periodic[1], InitVal[31:2].
- A TCFG write SHALL load TVAL<={InitVal,2'b00}.
- While En=1 and TVAL!=0, TVAL SHALL decrement by 1 each cycle.
- When TVAL steps 1->0, IS[11] SHALL be set.
- At TVAL=0: Periodic=1 SHALL reload; Periodic=0 SHALL hold 0 with no further interrupt.
- Writing TICLR bit0=1 SHALL clear IS[11]. TICLR SHALL read 0.
- If a timer set and a TICLR clear occur in the same cycle, the set SHALL win.
REQ-031 Without CSR_TIMER_EN, TCFG/TVAL/TICLR SHALL read 0 and ignore writes, and IS[11] SHALL be constant 0.

Structure
REQ-032 Shared package csr_pkg SHALL hold CSR address constants, field bit positions, writable masks, and ecode/esubcode constants (ECODE_INT 0x00, ECODE_ADE 0x08, ECODE_ALE 0x09, ECODE_SYS 0x0B, ESUBCODE_ADEF 0, ESUBCODE_ADEM 1).
REQ-033 Sub-module csr_timer SHALL contain TCFG/TVAL/interrupt logic, instantiated only under CSR_TIMER_EN.

Verification
REQ-034 Masked write: write CRMD, wvalue=0x7, wmask=0x4, from reset -> CRMD reads 0x0000000C.
REQ-035 Exception: CRMD.PLV=3, IE=1; wb_ex with ecode=0x09, wb_pc=0x1C000100, wb_vaddr=0x1003 -> PRMD=0x7, CRMD.PLV=0, IE=0, ERA=0x1C000100, BADV=0x1003, ESTAT[21:16]=0x09.
REQ-036 ertn: following REQ-035, assert ertn_flush -> CRMD.PLV=3, IE=1 next cycle.
REQ-037 Timer (CSR_TIMER_EN): TCFG=0x0000000B (InitVal=2, periodic, en) -> TVAL 8,7,...,0, IS[11]=1 on the cycle TVAL reaches 0, then reload to 8. TICLR=1 -> IS[11]=0. With LIE[11]=1 and IE=1, has_int pulses.
REQ-038 Conflict: wb_ex and csr_we to CRMD (wvalue=0x3, wmask=0x3) in the same cycle -> CRMD.PLV=0.
REQ-039 Unmapped: write 0xFFFFFFFF to csr_num 0x3FF -> reads 0, no other CSR changes.
